// File: rtl/fpu_issue_sched.sv
// FPU issue scheduler: scoreboard, hazard stall, FPU sequencing, FRF write arbitration.
// Optional macro FPU_ISSUE_BYPASS_EN adds fwd_fs/fwd_ft writeback forwarding.
module fpu_issue_sched #(
    parameter int LAT_ADD = 3,
    parameter int LAT_MUL = 5,
    parameter int LAT_DIV = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic       id_fp_op,
    input  logic       id_lwc,
    input  logic [5:0] id_funct,
    input  logic [4:0] id_fs,
    input  logic [4:0] id_ft,
    input  logic [4:0] id_fd,
    input  logic       wb_lwc_valid,
    input  logic [4:0] wb_lwc_rd,
    output logic       stall,
    output logic       fpu_start,
    output logic [1:0] fpu_op,
    output logic [4:0] fpu_dst,
    output logic       frf_we,
    output logic [4:0] frf_waddr,
    output logic       frf_wsel,
    output logic       fpu_busy,
`ifdef FPU_ISSUE_BYPASS_EN
    output logic       fwd_fs,
    output logic       fwd_ft,
`endif
    output logic       err_illegal
);

    typedef enum logic [1:0] {IDLE, BUSY, WB, WB_WAIT} state_t;

    localparam logic [3:0] ADD_M2 = 4'(LAT_ADD - 2);
    localparam logic [3:0] MUL_M2 = 4'(LAT_MUL - 2);
    localparam logic [3:0] DIV_M2 = 4'(LAT_DIV - 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] sb_q, sb_d;
    logic [1:0]  fpu_op_q, fpu_op_d;
    logic [4:0]  fpu_dst_q, fpu_dst_d;
    logic        fpu_start_q, fpu_start_d;

    logic       legal, fp_req, issue, fpu_wb;
    logic       raw_fs, raw_ft, waw, struct_haz;
    logic [3:0] lat_m2;

    assign legal  = (id_funct < 6'd4);
    assign fp_req = id_valid & id_fp_op & legal;
    assign fpu_wb = ((state_q == WB) || (state_q == WB_WAIT)) & ~wb_lwc_valid;

    always_comb begin
        raw_fs = (id_fs != 5'd0) & sb_q[id_fs];
        raw_ft = (id_ft != 5'd0) & sb_q[id_ft];
`ifdef FPU_ISSUE_BYPASS_EN
        // Result being written this cycle is forwarded instead of waited on.
        if (fpu_wb && id_fs == fpu_dst_q) raw_fs = 1'b0;
        if (fpu_wb && id_ft == fpu_dst_q) raw_ft = 1'b0;
`endif
    end

`ifdef FPU_ISSUE_BYPASS_EN
    assign fwd_fs = fp_req & fpu_wb & (id_fs == fpu_dst_q) & (id_fs != 5'd0);
    assign fwd_ft = fp_req & fpu_wb & (id_ft == fpu_dst_q) & (id_ft != 5'd0);
`endif

    assign waw = (id_fp_op & legal & (id_fd != 5'd0) & sb_q[id_fd])
               | (id_lwc & (id_ft != 5'd0) & sb_q[id_ft]);
    assign struct_haz = (state_q != IDLE)
                      & ~((state_q == WB) & ~wb_lwc_valid);

    assign stall = id_valid
                 & (waw | (id_fp_op & legal & (raw_fs | raw_ft | struct_haz)));
    assign issue = fp_req & ~stall;
    assign err_illegal = id_valid & id_fp_op & ~legal;

    always_comb begin
        unique case (1'b1)
            (id_funct[1:0] == 2'd3): lat_m2 = DIV_M2;
            (id_funct[1:0] == 2'd2): lat_m2 = MUL_M2;
            default:                 lat_m2 = ADD_M2;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sb_d        = sb_q;
        fpu_op_d    = fpu_op_q;
        fpu_dst_d   = fpu_dst_q;
        fpu_start_d = issue;
        if (fpu_wb) sb_d[fpu_dst_q] = 1'b0;
        // Set after clear so a same-register reissue keeps its entry.
        if (issue) begin
            sb_d[id_fd] = 1'b1;
            fpu_op_d    = id_funct[1:0];
            fpu_dst_d   = id_fd;
        end
        sb_d[0] = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = BUSY;
                    cnt_d   = lat_m2;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) state_d = WB;
                else cnt_d = cnt_q - 4'd1;
            end
            WB: begin
                if (wb_lwc_valid) begin
                    state_d = WB_WAIT;
                end else if (issue) begin
                    state_d = BUSY;
                    cnt_d   = lat_m2;
                end else begin
                    state_d = IDLE;
                end
            end
            WB_WAIT: begin
                if (!wb_lwc_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sb_q        <= '0;
            fpu_op_q    <= '0;
            fpu_dst_q   <= '0;
            fpu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sb_q        <= sb_d;
            fpu_op_q    <= fpu_op_d;
            fpu_dst_q   <= fpu_dst_d;
            fpu_start_q <= fpu_start_d;
        end
    end

    assign fpu_start = fpu_start_q;
    assign fpu_op    = fpu_op_q;
    assign fpu_dst   = fpu_dst_q;
    assign fpu_busy  = (state_q != IDLE);
    assign frf_we    = wb_lwc_valid | fpu_wb;
    assign frf_wsel  = wb_lwc_valid;
    assign frf_waddr = wb_lwc_valid ? wb_lwc_rd
                     : (fpu_wb ? fpu_dst_q : 5'd0);

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed self-checking bench for fpu_issue_sched (default latencies 3/5/12).
module tb_fpu_issue_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_fp_op, id_lwc;
    logic [5:0] id_funct;
    logic [4:0] id_fs, id_ft, id_fd;
    logic       wb_lwc_valid;
    logic [4:0] wb_lwc_rd;
    logic       stall, fpu_start, frf_we, frf_wsel, fpu_busy, err_illegal;
    logic [1:0] fpu_op;
    logic [4:0] fpu_dst, frf_waddr;
`ifdef FPU_ISSUE_BYPASS_EN
    logic       fwd_fs, fwd_ft;
`endif
    int ntests = 0;
    int nfail  = 0;

    fpu_issue_sched dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_fp_op(id_fp_op), .id_lwc(id_lwc),
        .id_funct(id_funct), .id_fs(id_fs), .id_ft(id_ft), .id_fd(id_fd),
        .wb_lwc_valid(wb_lwc_valid), .wb_lwc_rd(wb_lwc_rd),
        .stall(stall), .fpu_start(fpu_start), .fpu_op(fpu_op),
        .fpu_dst(fpu_dst), .frf_we(frf_we), .frf_waddr(frf_waddr),
        .frf_wsel(frf_wsel), .fpu_busy(fpu_busy),
`ifdef FPU_ISSUE_BYPASS_EN
        .fwd_fs(fwd_fs), .fwd_ft(fwd_ft),
`endif
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_valid = 0; id_fp_op = 0; id_lwc = 0; id_funct = 0;
        id_fs = 0; id_ft = 0; id_fd = 0;
        wb_lwc_valid = 0; wb_lwc_rd = 0;
    endtask

    task automatic fr(input logic [5:0] f, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d);
        id_valid = 1; id_fp_op = 1; id_lwc = 0; id_funct = f;
        id_fs = s; id_ft = t; id_fd = d;
    endtask

    task automatic drain(input int n);
        idle_in();
        repeat (n) next();
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        #12;
        chk("rst_start", fpu_start, 0);
        chk("rst_busy", fpu_busy, 0);
        chk("rst_we", frf_we, 0);
        chk("rst_stall", stall, 0);
        next();
        rst_n = 1;
        next();

        // T1: add.s fd=4 basic timing
        fr(6'd0, 5'd1, 5'd2, 5'd4); #1;
        chk("t1_c0_stall", stall, 0);
        next(); idle_in(); #1;
        chk("t1_c1_start", fpu_start, 1);
        chk("t1_c1_op", fpu_op, 0);
        chk("t1_c1_dst", fpu_dst, 4);
        chk("t1_c1_busy", fpu_busy, 1);
        chk("t1_c1_we", frf_we, 0);
        next();
        chk("t1_c2_start", fpu_start, 0);
        chk("t1_c2_busy", fpu_busy, 1);
        next();
        chk("t1_c3_we", frf_we, 1);
        chk("t1_c3_waddr", frf_waddr, 4);
        chk("t1_c3_wsel", frf_wsel, 0);
        chk("t1_c3_busy", fpu_busy, 1);
        next();
        chk("t1_c4_busy", fpu_busy, 0);
        chk("t1_c4_we", frf_we, 0);
        drain(2);

        // T2: RAW on fd=4
        fr(6'd0, 5'd1, 5'd2, 5'd4); #1;
        chk("t2_c0_stall", stall, 0);
        next(); fr(6'd1, 5'd4, 5'd3, 5'd5); #1;
        chk("t2_c1_stall", stall, 1);
        next();
        chk("t2_c2_stall", stall, 1);
        next();
`ifdef FPU_ISSUE_BYPASS_EN
        chk("t2_c3_stall", stall, 0);
        chk("t2_c3_fwd_fs", fwd_fs, 1);
        chk("t2_c3_fwd_ft", fwd_ft, 0);
`else
        chk("t2_c3_stall", stall, 1);
        chk("t2_c3_we", frf_we, 1);
        next();
        chk("t2_c4_stall", stall, 0);
`endif
        next(); idle_in(); #1;
        chk("t2_dep_start", fpu_start, 1);
        chk("t2_dep_op", fpu_op, 1);
        chk("t2_dep_dst", fpu_dst, 5);
        drain(5);
        chk("t2_done_busy", fpu_busy, 0);

        // T3: mul.s fd=9 loses port to lwc rd=7
        fr(6'd2, 5'd1, 5'd2, 5'd9); #1;
        chk("t3_c0_stall", stall, 0);
        next(); idle_in(); #1;
        chk("t3_c1_op", fpu_op, 2);
        repeat (4) next();
        wb_lwc_valid = 1; wb_lwc_rd = 5'd7; #1;
        chk("t3_c5_we", frf_we, 1);
        chk("t3_c5_waddr", frf_waddr, 7);
        chk("t3_c5_wsel", frf_wsel, 1);
        next(); idle_in(); #1;
        chk("t3_c6_we", frf_we, 1);
        chk("t3_c6_waddr", frf_waddr, 9);
        chk("t3_c6_wsel", frf_wsel, 0);
        chk("t3_c6_busy", fpu_busy, 1);
        next();
        chk("t3_c7_busy", fpu_busy, 0);
        chk("t3_c7_we", frf_we, 0);
        drain(1);

        // T4: div.s fd=2 structural stall, lwc WAW on f2
        fr(6'd3, 5'd1, 5'd3, 5'd2); #1;
        chk("t4_c0_stall", stall, 0);
        next();
        id_valid = 1; id_fp_op = 0; id_lwc = 1; id_ft = 5'd2; #1;
        chk("t4_lwc_waw", stall, 1);
        for (int c = 1; c <= 11; c++) begin
            fr(6'd0, 5'd5, 5'd6, 5'd8); #1;
            chk($sformatf("t4_c%0d_stall", c), stall, 1);
            next();
        end
        fr(6'd0, 5'd5, 5'd6, 5'd8); #1;
        chk("t4_c12_stall", stall, 0);
        chk("t4_c12_we", frf_we, 1);
        chk("t4_c12_waddr", frf_waddr, 2);
        next(); idle_in(); #1;
        chk("t4_c13_start", fpu_start, 1);
        chk("t4_c13_dst", fpu_dst, 8);
        chk("t4_c13_busy", fpu_busy, 1);
        drain(5);

        // T5: illegal funct
        fr(6'h3F, 5'd1, 5'd2, 5'd3); #1;
        chk("t5_err", err_illegal, 1);
        chk("t5_stall", stall, 0);
        next(); idle_in(); #1;
        chk("t5_err_off", err_illegal, 0);
        chk("t5_start", fpu_start, 0);
        chk("t5_busy", fpu_busy, 0);

        // T6: reset mid div.s fd=2
        fr(6'd3, 5'd1, 5'd3, 5'd2); #1;
        chk("t6_c0_stall", stall, 0);
        next(); idle_in();
        repeat (4) next();
        rst_n = 0; #1;
        chk("t6_rst_busy", fpu_busy, 0);
        chk("t6_rst_we", frf_we, 0);
        chk("t6_rst_start", fpu_start, 0);
        chk("t6_rst_dst", fpu_dst, 0);
        next();
        rst_n = 1;
        next();
        fr(6'd0, 5'd2, 5'd3, 5'd6); #1;
        chk("t6_nostall", stall, 0);
        next(); idle_in(); #1;
        chk("t6_start", fpu_start, 1);
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("t6_no_f2_wb_%0d", c),
                32'(frf_we && frf_waddr == 5'd2), 0);
            next();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
